// File: rtl/rptr_empty_level_if.sv
// Read-side pointer/flag bundle between the read controller and the read-domain pointer block.
// The slave modport is the pointer block; the master modport is the reader that drives it.
interface rptr_empty_level_if #(
    parameter int add_size = 4
);
    logic                rd_inc;
    logic                rd_flush;
    logic                clr_err;
    logic [add_size:0]   ae_level;
    logic [add_size:0]   wr_ptr_sync;
    logic [add_size:0]   rd_ptr;
    logic [add_size-1:0] rd_addr;
    logic                empty;
    logic                almost_empty;
    logic [add_size:0]   rd_level;
    logic                underflow;
    logic                underflow_err;
    logic                ptr_err;

    modport slave (
        input  rd_inc, rd_flush, clr_err, ae_level, wr_ptr_sync,
        output rd_ptr, rd_addr, empty, almost_empty, rd_level,
               underflow, underflow_err, ptr_err
    );

    modport master (
        output rd_inc, rd_flush, clr_err, ae_level, wr_ptr_sync,
        input  rd_ptr, rd_addr, empty, almost_empty, rd_level,
               underflow, underflow_err, ptr_err
    );
endinterface

// File: rtl/rptr_empty_level.sv
// Read-domain pointer block of the async FIFO: binary/Gray read pointers, registered empty,
// fill level, almost-empty, underflow detection, single-cycle flush and pointer-sanity error.
module rptr_empty_level #(
    parameter int add_size = 4
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    rptr_empty_level_if.slave    bus
);
    localparam int PW = add_size + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(1 << add_size);

    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_level_q, rd_level_d;
    logic [PW-1:0] lvl_next;
    logic          lvl_bad;
    logic          pop_underflow;
    logic          empty_q, empty_d;
    logic          almost_empty_q, almost_empty_d;
    logic          underflow_q, underflow_d;
    logic          underflow_err_q, underflow_err_d;
    logic          ptr_err_q, ptr_err_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wbin[gi] = ^bus.wr_ptr_sync[PW-1:gi];
        end
    endgenerate

    always_comb begin
        rbin_d = rbin_q;
        if (bus.rd_flush) begin
            rbin_d = wbin;
        end else if (bus.rd_inc && !empty_q) begin
            rbin_d = rbin_q + PW'(1);
        end
        rd_ptr_d        = (rbin_d >> 1) ^ rbin_d;
        lvl_next        = wbin - rbin_d;
        lvl_bad         = (lvl_next > DEPTH_L);
        pop_underflow   = bus.rd_inc & empty_q & ~bus.rd_flush;

        empty_d         = (rd_ptr_d == bus.wr_ptr_sync);
        // A corrupt level is never published; the last sane value is kept instead.
        rd_level_d      = lvl_bad ? rd_level_q : lvl_next;
        almost_empty_d  = (lvl_next <= bus.ae_level);
        underflow_d     = pop_underflow;
        underflow_err_d = ~bus.clr_err & (underflow_err_q | pop_underflow);
        ptr_err_d       = ~bus.clr_err & (ptr_err_q | lvl_bad);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rbin_q          <= '0;
            rd_ptr_q        <= '0;
            rd_level_q      <= '0;
            empty_q         <= 1'b1;
            almost_empty_q  <= 1'b1;
            underflow_q     <= 1'b0;
            underflow_err_q <= 1'b0;
            ptr_err_q       <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rd_ptr_q        <= rd_ptr_d;
            rd_level_q      <= rd_level_d;
            empty_q         <= empty_d;
            almost_empty_q  <= almost_empty_d;
            underflow_q     <= underflow_d;
            underflow_err_q <= underflow_err_d;
            ptr_err_q       <= ptr_err_d;
        end
    end

    assign bus.rd_ptr        = rd_ptr_q;
    assign bus.rd_addr       = rbin_q[add_size-1:0];
    assign bus.empty         = empty_q;
    assign bus.almost_empty  = almost_empty_q;
    assign bus.rd_level      = rd_level_q;
    assign bus.underflow     = underflow_q;
    assign bus.underflow_err = underflow_err_q;
    assign bus.ptr_err       = ptr_err_q;
endmodule

// File: tb/tb_rptr_empty_level.sv
// Directed bench for rptr_empty_level with add_size=4 (DEPTH=16, 5-bit pointers).
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_rptr_empty_level;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] rb;

    rptr_empty_level_if #(.add_size(4)) bus ();

    rptr_empty_level #(.add_size(4)) dut (
        .rd_clk (clk),
        .rd_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rd_inc = 0; bus.rd_flush = 0; bus.clr_err = 0;
        bus.ae_level = 5'd2; bus.wr_ptr_sync = 5'd0;
        tick(); tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b exp 1", bus.almost_empty); end
        checks++; if (bus.rd_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.rd_level); end
        checks++; if (bus.rd_addr !== 4'd0 || bus.rd_ptr !== 5'd0) begin errors++; $display("FAIL reset_ptr got addr %0d ptr %0d exp 0 0", bus.rd_addr, bus.rd_ptr); end
        checks++; if ({bus.underflow, bus.underflow_err, bus.ptr_err} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b exp 000", {bus.underflow, bus.underflow_err, bus.ptr_err}); end
        rst = 1'b0;
        rb = 5'd0;
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL idle_empty got %b exp 1", bus.empty); end
        $display("reset: empty=%b level=%0d", bus.empty, bus.rd_level);
    endtask

    task automatic test_basic_pop();
        bus.wr_ptr_sync = gray(5'd5);
        tick();
        checks++; if (bus.empty !== 1'b0 || bus.rd_level !== 5'd5) begin errors++; $display("FAIL fill5 got empty %b level %0d exp 0 5", bus.empty, bus.rd_level); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL fill5_ae got %b exp 0", bus.almost_empty); end
        bus.rd_inc = 1;
        tick();
        checks++; if (bus.rd_addr !== 4'd1 || bus.rd_level !== 5'd4) begin errors++; $display("FAIL pop1 got addr %0d level %0d exp 1 4", bus.rd_addr, bus.rd_level); end
        tick(); tick();
        bus.rd_inc = 0;
        rb = 5'd3;
        checks++; if (bus.rd_level !== 5'd2 || bus.almost_empty !== 1'b1) begin errors++; $display("FAIL pop3 got level %0d ae %b exp 2 1", bus.rd_level, bus.almost_empty); end
        checks++; if (bus.rd_addr !== 4'd3 || bus.rd_ptr !== gray(5'd3)) begin errors++; $display("FAIL pop3_ptr got addr %0d ptr %h exp 3 %h", bus.rd_addr, bus.rd_ptr, gray(5'd3)); end
        $display("basic_pop: level=%0d addr=%0d", bus.rd_level, bus.rd_addr);
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        prev = bus.rd_ptr;
        for (int i = 0; i < 40; i++) begin
            bus.wr_ptr_sync = gray(rb + 5'd4);
            bus.rd_inc = 1;
            tick();
            rb = rb + 5'd1;
            checks++;
            if (bus.rd_ptr !== gray(rb) || bus.rd_addr !== rb[3:0] || $countones(bus.rd_ptr ^ prev) != 1) begin
                errors++; $display("FAIL wrap_ptr[%0d] got ptr %h addr %0d exp ptr %h addr %0d", i, bus.rd_ptr, bus.rd_addr, gray(rb), rb[3:0]);
            end
            checks++;
            if (bus.rd_level !== 5'd3 || bus.empty !== 1'b0) begin
                errors++; $display("FAIL wrap_level[%0d] got level %0d empty %b exp 3 0", i, bus.rd_level, bus.empty);
            end
            prev = bus.rd_ptr;
        end
        bus.rd_inc = 0;
        $display("wrap: 40 pops, rbin now %0d", rb);
    endtask

    task automatic test_underflow();
        bus.wr_ptr_sync = gray(rb);
        tick();
        checks++; if (bus.empty !== 1'b1 || bus.rd_level !== 5'd0) begin errors++; $display("FAIL drain got empty %b level %0d exp 1 0", bus.empty, bus.rd_level); end
        bus.ae_level = 5'd0;
        bus.rd_inc = 1;
        tick();
        bus.rd_inc = 0;
        checks++; if (bus.underflow !== 1'b1 || bus.underflow_err !== 1'b1) begin errors++; $display("FAIL uf_pulse got uf %b err %b exp 1 1", bus.underflow, bus.underflow_err); end
        checks++; if (bus.rd_addr !== rb[3:0] || bus.almost_empty !== 1'b1) begin errors++; $display("FAIL uf_hold got addr %0d ae %b exp %0d 1", bus.rd_addr, bus.almost_empty, rb[3:0]); end
        tick();
        checks++; if (bus.underflow !== 1'b0 || bus.underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got uf %b err %b exp 0 1", bus.underflow, bus.underflow_err); end
        bus.clr_err = 1;
        tick();
        bus.clr_err = 0;
        bus.ae_level = 5'd2;
        checks++; if (bus.underflow_err !== 1'b0) begin errors++; $display("FAIL uf_clear got %b exp 0", bus.underflow_err); end
        $display("underflow: pulse and clear done");
    endtask

    task automatic test_flush();
        bus.wr_ptr_sync = gray(rb + 5'd7);
        tick();
        checks++; if (bus.rd_level !== 5'd7) begin errors++; $display("FAIL pre_flush got level %0d exp 7", bus.rd_level); end
        bus.rd_flush = 1; bus.rd_inc = 1;
        tick();
        bus.rd_flush = 0; bus.rd_inc = 0;
        rb = rb + 5'd7;
        checks++; if (bus.rd_ptr !== gray(rb) || bus.rd_addr !== rb[3:0]) begin errors++; $display("FAIL flush_ptr got ptr %h addr %0d exp %h %0d", bus.rd_ptr, bus.rd_addr, gray(rb), rb[3:0]); end
        checks++; if (bus.empty !== 1'b1 || bus.rd_level !== 5'd0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL flush_flags got empty %b level %0d uf %b exp 1 0 0", bus.empty, bus.rd_level, bus.underflow); end
        $display("flush: rbin now %0d", rb);
    endtask

    task automatic test_ptr_err();
        bus.wr_ptr_sync = gray(rb + 5'd5);
        tick();
        bus.wr_ptr_sync = gray(rb + 5'd20);
        tick();
        checks++; if (bus.ptr_err !== 1'b1 || bus.rd_level !== 5'd5) begin errors++; $display("FAIL ptr_err got err %b level %0d exp 1 5", bus.ptr_err, bus.rd_level); end
        bus.wr_ptr_sync = gray(rb + 5'd5);
        bus.ae_level = 5'd16;
        tick();
        checks++; if (bus.ptr_err !== 1'b1 || bus.almost_empty !== 1'b1) begin errors++; $display("FAIL ptr_sticky got err %b ae %b exp 1 1", bus.ptr_err, bus.almost_empty); end
        bus.clr_err = 1;
        tick();
        bus.clr_err = 0;
        bus.ae_level = 5'd2;
        checks++; if (bus.ptr_err !== 1'b0) begin errors++; $display("FAIL ptr_clear got %b exp 0", bus.ptr_err); end
        $display("ptr_err: set, hold, clear done");
    endtask

    task automatic test_last_entry();
        bus.wr_ptr_sync = gray(rb + 5'd1);
        tick();
        checks++; if (bus.rd_level !== 5'd1 || bus.empty !== 1'b0) begin errors++; $display("FAIL one_entry got level %0d empty %b exp 1 0", bus.rd_level, bus.empty); end
        bus.rd_inc = 1;
        tick();
        bus.rd_inc = 0;
        rb = rb + 5'd1;
        checks++; if (bus.rd_level !== 5'd0 || bus.empty !== 1'b1 || bus.rd_addr !== rb[3:0]) begin errors++; $display("FAIL last_pop got level %0d empty %b addr %0d exp 0 1 %0d", bus.rd_level, bus.empty, bus.rd_addr, rb[3:0]); end
        $display("last_entry: level=%0d empty=%b", bus.rd_level, bus.empty);
    endtask

    task automatic test_midop_reset();
        bus.wr_ptr_sync = gray(rb + 5'd3);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.empty !== 1'b1 || bus.rd_level !== 5'd0 || bus.rd_addr !== 4'd0 || bus.rd_ptr !== 5'd0) begin errors++; $display("FAIL async_reset got empty %b level %0d addr %0d ptr %h exp 1 0 0 0", bus.empty, bus.rd_level, bus.rd_addr, bus.rd_ptr); end
        bus.wr_ptr_sync = 5'd0;
        tick();
        rst = 1'b0;
        $display("midop_reset: state cleared");
    endtask

    initial begin
        test_reset();
        test_basic_pop();
        test_wrap();
        test_underflow();
        test_flush();
        test_ptr_err();
        test_last_entry();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
